// File: rtl/clock_pkg.sv
// ============================================================================
// Module   : clock_pkg
// Purpose  : Shared widths and phase type for the clock_gen block.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package clock_pkg;
  localparam int c_ph_w  = 16;
  localparam int c_cnt_w = 32;

  typedef logic [c_ph_w-1:0] clk_phase_t;
endpackage

`default_nettype wire

// File: rtl/clock_phase_ctr.sv
// ============================================================================
// Module   : clock_phase_ctr
// Purpose  : Wrapping phase counter (0..PERIOD-1) with enable; exposes the
//            phase the next edge will load.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module clock_phase_ctr
  import clock_pkg::*;
#(
  parameter int PERIOD = 10
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       en_i,
  output clk_phase_t ph_n_o
);

  localparam clk_phase_t c_last = clk_phase_t'(PERIOD - 1);

  clk_phase_t ph_q;
  clk_phase_t ph_d;

  always_comb begin
    ph_d = (ph_q == c_last) ? '0 : ph_q + 1'b1;
  end

  // Reset parks on the last phase so the first enabled edge wraps to 0.
  always_ff @(posedge clk) begin
    if (reset) begin
      ph_q <= c_last;
    end else if (en_i) begin
      ph_q <= ph_d;
    end
  end

  assign ph_n_o = ph_d;

endmodule

`default_nettype wire

// File: rtl/clock_gen.sv
// ============================================================================
// Module   : clock_gen
// Purpose  : Divided 50%-duty clock with rise/fall strobes and an optional
//            rising-edge counter (enabled by CLOCK_GEN_CYCLE_COUNT_EN).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module clock_gen
  import clock_pkg::*;
#(
  parameter int PERIOD = 10
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               en,
  output logic               gen_clk,
  output logic               rise_tick,
  output logic               fall_tick,
  output logic [c_cnt_w-1:0] cycle_count
);

  localparam clk_phase_t c_high = clk_phase_t'(PERIOD / 2);

  generate
    if ((PERIOD < 2) || (PERIOD > 65535)) begin : g_period_check
      $fatal(1, "clock_gen: PERIOD must be within 2..65535");
    end
  endgenerate

  clk_phase_t ph_n;

  clock_phase_ctr #(
    .PERIOD (PERIOD)
  ) u_phase_ctr (
    .clk    (clk),
    .reset  (reset),
    .en_i   (en),
    .ph_n_o (ph_n)
  );

  logic gen_clk_q;
  logic rise_q;
  logic fall_q;
  logic gen_clk_d;
  logic rise_d;
  logic fall_d;

  always_comb begin
    gen_clk_d = (ph_n < c_high);
    rise_d    = (ph_n == '0);
    fall_d    = (ph_n == c_high);
  end

  // Strobes are single-cycle: a disabled edge clears them while gen_clk holds.
  always_ff @(posedge clk) begin
    if (reset) begin
      gen_clk_q <= 1'b0;
      rise_q    <= 1'b0;
      fall_q    <= 1'b0;
    end else if (en) begin
      gen_clk_q <= gen_clk_d;
      rise_q    <= rise_d;
      fall_q    <= fall_d;
    end else begin
      rise_q    <= 1'b0;
      fall_q    <= 1'b0;
    end
  end

  assign gen_clk   = gen_clk_q;
  assign rise_tick = rise_q;
  assign fall_tick = fall_q;

`ifdef CLOCK_GEN_CYCLE_COUNT_EN
  logic [c_cnt_w-1:0] cycle_cnt_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      cycle_cnt_q <= '0;
    end else if (en && rise_d) begin
      cycle_cnt_q <= cycle_cnt_q + 1'b1;
    end
  end

  assign cycle_count = cycle_cnt_q;
`else
  assign cycle_count = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_clock_gen.sv
// ============================================================================
// Module   : tb_clock_gen
// Purpose  : Self-checking bench for clock_gen at PERIOD 10, 7 and 2.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_clock_gen;

  logic        clk = 1'b0;
  logic [2:0]  rst;
  logic [2:0]  en;
  logic [2:0]  gclk;
  logic [2:0]  rise;
  logic [2:0]  fall;
  logic [31:0] cnt [3];

  int errors = 0;
  int checks = 0;
  bit chk_on = 1'b0;

  always #5 clk = ~clk;

  clock_gen #(.PERIOD(10)) u_dut10 (
    .clk(clk), .reset(rst[0]), .en(en[0]),
    .gen_clk(gclk[0]), .rise_tick(rise[0]), .fall_tick(fall[0]), .cycle_count(cnt[0]));

  clock_gen #(.PERIOD(7)) u_dut7 (
    .clk(clk), .reset(rst[1]), .en(en[1]),
    .gen_clk(gclk[1]), .rise_tick(rise[1]), .fall_tick(fall[1]), .cycle_count(cnt[1]));

  clock_gen #(.PERIOD(2)) u_dut2 (
    .clk(clk), .reset(rst[2]), .en(en[2]),
    .gen_clk(gclk[2]), .rise_tick(rise[2]), .fall_tick(fall[2]), .cycle_count(cnt[2]));

  // Model: position within the period follows from the count of enabled edges.
  int          per [3] = '{10, 7, 2};
  longint      m_k [3];
  logic        m_gen [3];
  logic        m_rise [3];
  logic        m_fall [3];
  logic [31:0] m_cnt [3];

  always @(posedge clk) begin
    for (int d = 0; d < 3; d++) begin
      if (rst[d]) begin
        m_k[d] = 0; m_gen[d] = 1'b0; m_rise[d] = 1'b0; m_fall[d] = 1'b0; m_cnt[d] = '0;
      end else if (en[d]) begin
        longint pos;
        m_k[d]    = m_k[d] + 1;
        pos       = (m_k[d] - 1) % per[d];
        m_gen[d]  = (pos < per[d] / 2);
        m_rise[d] = (pos == 0);
        m_fall[d] = (pos == per[d] / 2);
        if (m_rise[d]) m_cnt[d] = m_cnt[d] + 32'd1;
      end else begin
        m_rise[d] = 1'b0;
        m_fall[d] = 1'b0;
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] exp_cnt(input int d);
`ifdef CLOCK_GEN_CYCLE_COUNT_EN
    return m_cnt[d];
`else
    return 32'd0 + 0 * d;
`endif
  endfunction

  always @(negedge clk) begin
    if (chk_on) begin
      for (int d = 0; d < 3; d++) begin
        check($sformatf("d%0d_gen", d),  {31'd0, gclk[d]}, {31'd0, m_gen[d]});
        check($sformatf("d%0d_rise", d), {31'd0, rise[d]}, {31'd0, m_rise[d]});
        check($sformatf("d%0d_fall", d), {31'd0, fall[d]}, {31'd0, m_fall[d]});
        check($sformatf("d%0d_cnt", d),  cnt[d], exp_cnt(d));
      end
    end
  end

  logic [19:0] g10, r10, f10, mg10, mr10, mf10;
  logic [13:0] g7, r7, f7, mg7, mr7, mf7;
  logic [13:0] ge, re, fe, mge, mre, mfe;
  int guard;

  initial begin
    rst = 3'b111;
    en  = 3'b111;
    repeat (3) @(negedge clk);
    chk_on = 1'b1;
    for (int d = 0; d < 3; d++) begin
      check($sformatf("rst_state_d%0d", d), {gclk[d], rise[d], fall[d], (cnt[d] != 0)}, 4'b0000);
    end

    // PERIOD 10 and 7 free-running from reset release.
    rst = 3'b000;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      g10[i] = gclk[0]; r10[i] = rise[0]; f10[i] = fall[0];
      mg10[i] = m_gen[0]; mr10[i] = m_rise[0]; mf10[i] = m_fall[0];
      if (i < 14) begin
        g7[i] = gclk[1]; r7[i] = rise[1]; f7[i] = fall[1];
        mg7[i] = m_gen[1]; mr7[i] = m_rise[1]; mf7[i] = m_fall[1];
      end
    end
    check("p10_gen_pat",  {12'd0, g10},  32'h07C1F);
    check("p10_rise_pat", {12'd0, r10},  32'h00401);
    check("p10_fall_pat", {12'd0, f10},  32'h08020);
    check("model_p10",    {mg10, mr10, mf10, 12'd0} >> 12, {20'h07C1F, 20'h00401, 20'h08020, 12'd0} >> 12);
    check("p7_gen_pat",   {18'd0, g7},   32'h0387);
    check("p7_rise_pat",  {18'd0, r7},   32'h0081);
    check("p7_fall_pat",  {18'd0, f7},   32'h0408);
    check("model_p7",     {4'd0, mg7, mr7} , {4'd0, 14'h0387, 14'h0081});
    check("model_p7_fall", {18'd0, mf7}, 32'h0408);

    // Enable dropped for three edges starting after phase 2.
    for (int i = 0; i < 14; i++) begin
      en[0] = !(i >= 3 && i <= 5);
      @(negedge clk);
      ge[i] = gclk[0]; re[i] = rise[0]; fe[i] = fall[0];
      mge[i] = m_gen[0]; mre[i] = m_rise[0]; mfe[i] = m_fall[0];
    end
    en[0] = 1'b1;
    check("en_gen_pat",  {18'd0, ge}, 32'h20FF);
    check("en_rise_pat", {18'd0, re}, 32'h2001);
    check("en_fall_pat", {18'd0, fe}, 32'h0100);
    check("model_en",    {4'd0, mge, mre}, {4'd0, 14'h20FF, 14'h2001});
    check("model_en_fall", {18'd0, mfe}, 32'h0100);

    // Reset mid-period at phase 6.
    repeat (6) @(negedge clk);
    rst[0] = 1'b1;
    @(negedge clk);
    check("midrst_outs", {gclk[0], rise[0], fall[0], (cnt[0] != 0)}, 4'b0000);
    rst[0] = 1'b0;
    @(negedge clk);
    check("post_rst_rise", {gclk[0], rise[0], fall[0]}, 3'b110);
`ifdef CLOCK_GEN_CYCLE_COUNT_EN
    check("post_rst_cnt", cnt[0], 32'd1);
`else
    check("post_rst_cnt", cnt[0], 32'd0);
`endif

    // PERIOD 2 run to 300 edges.
    guard = 0;
    while (m_k[2] < 300 && guard < 1000) begin
      @(negedge clk);
      guard++;
    end
    check("p2_edges_reached", m_k[2][31:0], 32'd300);
`ifdef CLOCK_GEN_CYCLE_COUNT_EN
    check("p2_cnt_300", cnt[2], 32'd150);
    #1;
    force u_dut2.cycle_cnt_q = 32'hFFFF_FFFF;
    m_cnt[2] = 32'hFFFF_FFFF;
    #1;
    release u_dut2.cycle_cnt_q;
    @(negedge clk);
    check("p2_cnt_wrap", cnt[2], 32'd0);
    check("p2_wrap_rise", {31'd0, rise[2]}, 32'd1);
`else
    check("p2_cnt_300", cnt[2], 32'd0);
`endif

    repeat (4) @(negedge clk);
    chk_on = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
